shared_ram_responder: RTL

- Responder end of the user-logic memory/flag protocol; the initiator is the user FPGA processing engine.
- Owns the single-port data SRAM (external macro, 1-cycle read latency) and the 32-bit command/status flag register at FLAG_ADDR.
- Arbitrates SRAM ownership between the PCI host side and the user engine: START from host hands ownership to user, DONE from user hands it back.
- Sits between the PCI bridge and the user engine.

---
 rtl/shared_ram_responder.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/shared_ram_responder.sv
// Responder side of the user-logic memory/flag protocol.
// Owns the single-port data SRAM (external macro, 1-cycle read latency) and the
// command/status flag register, and hands SRAM ownership between the PCI host
// (START_CMD written to the flag) and the user engine (DONE_CODE via flag_we).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pci_*                    host word access; rd_valid/rd_data one cycle after a read,
//                            pci_busy flags a rejected host access in the same cycle
//   req_addr, rd_req, FPGA_wr_en, write_data, rd_data, rd_ready
//                            user data port; rd_ready one cycle after a read
//   flag_we, out_flag, in_flag   user flag write / current flag value
//   owner_user, user_wr_count, err_count   status
//   ram_*                    SRAM macro port (address/write forwarded combinationally)
module shared_ram_responder #(
    parameter int unsigned         ADDR_W    = 21,
    parameter int unsigned         DATA_W    = 32,
    parameter logic [ADDR_W-1:0]   FLAG_ADDR = ADDR_W'(21'h07FFFE),
    parameter logic [DATA_W-1:0]   START_CMD = DATA_W'(32'h0001_0000),
    parameter logic [DATA_W-1:0]   DONE_CODE = DATA_W'(32'h0000_0004)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pci_req_addr,
    input  logic [DATA_W-1:0] pci_input_data,
    input  logic              pci_wr_en,
    input  logic              pci_rd_en,
    output logic [DATA_W-1:0] pci_rd_data,
    output logic              pci_rd_valid,
    output logic              pci_busy,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              rd_req,
    input  logic              FPGA_wr_en,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_ready,
    input  logic              flag_we,
    input  logic [DATA_W-1:0] out_flag,
    output logic [DATA_W-1:0] in_flag,
    output logic              owner_user,
    output logic [31:0]       user_wr_count,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned ERR_W     = 16;
    localparam int unsigned ERR_SUM_W = ERR_W + 1;

    typedef enum logic {ST_HOST = 1'b0, ST_USER = 1'b1} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] flag_q, flag_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              pci_rd_ram_q, pci_rd_ram_d;
    logic              pci_rd_flag_q, pci_rd_flag_d;
    logic              usr_rd_ram_q, usr_rd_ram_d;
    logic              usr_rd_flag_q, usr_rd_flag_d;
    logic [DATA_W-1:0] pci_hold_q, pci_hold_d;
    logic [DATA_W-1:0] usr_hold_q, usr_hold_d;

    logic              ram_we_c;
    logic              pci_busy_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic [1:0]        err_inc;
    logic [ERR_SUM_W-1:0] err_sum;

    // Request decode; a simultaneous host write takes precedence over a host read
    logic pci_flag_hit, usr_flag_hit, usr_acc;
    logic pci_flag_wr, pci_flag_rd, pci_data_wr, pci_data_rd, pci_flag_win;

    assign pci_flag_hit = (pci_req_addr == FLAG_ADDR);
    assign usr_flag_hit = (req_addr == FLAG_ADDR);
    assign usr_acc      = rd_req | FPGA_wr_en;
    assign pci_flag_wr  = pci_wr_en & pci_flag_hit;
    assign pci_flag_rd  = pci_rd_en & ~pci_wr_en & pci_flag_hit;
    assign pci_data_wr  = pci_wr_en & ~pci_flag_hit;
    assign pci_data_rd  = pci_rd_en & ~pci_wr_en & ~pci_flag_hit;
    // The user flag write always beats a host flag write in the same cycle
    assign pci_flag_win = pci_flag_wr & ~flag_we;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HOST;
        end else begin
            state_q <= state_d;
        end
    end

    // Ownership transitions
    always_comb begin
        state_d = state_q;
        if ((state_q == ST_USER) && flag_we && (out_flag == DONE_CODE)) begin
            state_d = ST_HOST;
        end else if (pci_flag_win && (pci_input_data == START_CMD)) begin
            state_d = ST_USER;
        end
    end

    // Access arbitration, SRAM forwarding and datapath next values
    always_comb begin
        ram_we_c      = 1'b0;
        ram_addr_c    = '0;
        ram_wdata_c   = '0;
        pci_busy_c    = 1'b0;
        err_inc       = 2'd0;
        flag_d        = flag_q;
        wr_cnt_d      = wr_cnt_q;
        pci_rd_ram_d  = 1'b0;
        pci_rd_flag_d = 1'b0;
        usr_rd_ram_d  = 1'b0;
        usr_rd_flag_d = 1'b0;
        pci_hold_d    = pci_hold_q;
        usr_hold_d    = usr_hold_q;

        if (pci_flag_wr && flag_we) begin
            pci_busy_c = 1'b1;
            err_inc    = err_inc + 2'd1;
        end
        if (pci_flag_rd) begin
            pci_rd_flag_d = 1'b1;
            pci_hold_d    = flag_q;
        end

        case (state_q)
            ST_HOST: begin
                if (pci_data_wr) begin
                    ram_we_c    = 1'b1;
                    ram_addr_c  = pci_req_addr;
                    ram_wdata_c = pci_input_data;
                end else if (pci_data_rd) begin
                    ram_addr_c   = pci_req_addr;
                    pci_rd_ram_d = 1'b1;
                end
                if (usr_acc) begin
                    err_inc = err_inc + 2'd1;
                end
            end
            ST_USER: begin
                if (pci_data_wr || pci_data_rd) begin
                    pci_busy_c = 1'b1;
                    err_inc    = err_inc + 2'd1;
                end
                if (usr_acc) begin
                    if (usr_flag_hit) begin
                        // The flag is never reachable as SRAM; writes through the data port are illegal
                        if (FPGA_wr_en) begin
                            err_inc = err_inc + 2'd1;
                        end else begin
                            usr_rd_flag_d = 1'b1;
                            usr_hold_d    = flag_q;
                        end
                    end else begin
                        ram_addr_c = req_addr;
                        if (FPGA_wr_en) begin
                            ram_we_c    = 1'b1;
                            ram_wdata_c = write_data;
                            wr_cnt_d    = wr_cnt_q + CNT_W'(1);
                        end else begin
                            usr_rd_ram_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase

        if (flag_we) begin
            flag_d = out_flag;
        end else if (pci_flag_wr) begin
            flag_d = pci_input_data;
            // START opens a fresh session, also when already in USER
            if (pci_input_data == START_CMD) begin
                wr_cnt_d = '0;
            end
        end

        err_sum = {1'b0, err_q} + ERR_SUM_W'(err_inc);
        err_d   = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q        <= '0;
            wr_cnt_q      <= '0;
            err_q         <= '0;
            pci_rd_ram_q  <= 1'b0;
            pci_rd_flag_q <= 1'b0;
            usr_rd_ram_q  <= 1'b0;
            usr_rd_flag_q <= 1'b0;
            pci_hold_q    <= '0;
            usr_hold_q    <= '0;
        end else begin
            flag_q        <= flag_d;
            wr_cnt_q      <= wr_cnt_d;
            err_q         <= err_d;
            pci_rd_ram_q  <= pci_rd_ram_d;
            pci_rd_flag_q <= pci_rd_flag_d;
            usr_rd_ram_q  <= usr_rd_ram_d;
            usr_rd_flag_q <= usr_rd_flag_d;
            pci_hold_q    <= pci_hold_d;
            usr_hold_q    <= usr_hold_d;
        end
    end

    // Strobes and read returns are suppressed while reset is held so an
    // abandoned read never reports valid
    assign ram_we        = ram_we_c & ~rst;
    assign ram_addr      = ram_addr_c;
    assign ram_wdata     = ram_wdata_c;
    assign pci_busy      = pci_busy_c & ~rst;
    assign pci_rd_valid  = (pci_rd_ram_q | pci_rd_flag_q) & ~rst;
    assign rd_ready      = (usr_rd_ram_q | usr_rd_flag_q) & ~rst;
    assign in_flag       = flag_q;
    assign owner_user    = (state_q == ST_USER);
    assign user_wr_count = wr_cnt_q;
    assign err_count     = err_q;

    // Read data is zero unless its valid is high
    always_comb begin
        pci_rd_data = '0;
        rd_data     = '0;
        if (!rst) begin
            if (pci_rd_ram_q) begin
                pci_rd_data = ram_rdata;
            end else if (pci_rd_flag_q) begin
                pci_rd_data = pci_hold_q;
            end
            if (usr_rd_ram_q) begin
                rd_data = ram_rdata;
            end else if (usr_rd_flag_q) begin
                rd_data = usr_hold_q;
            end
        end
    end

endmodule
